// File: rtl/hrm_seq_25b_pkg.sv
// rtl/hrm_seq_25b_pkg.sv - shared types, constants and fixed-point multiply for the rotation sequencer
package hrm_seq_25b_pkg;

  // Signed two's-complement fixed point with 23 fractional bits, so the value 1.0 is 2**23.
  typedef logic [24:0] val25_t;
  typedef val25_t angle25_t [1:0];

  localparam int     FRAC_W   = 23;
  localparam val25_t ZERO_25B = 25'h000_0000;
  localparam val25_t ONE_25B  = 25'h080_0000;

  typedef enum logic [1:0] {IDLE, PRIME, HOLD, DONE} state_t;

  // The product is truncated toward minus infinity, and wrap-around on overflow is left in place.
  function automatic val25_t mlt_25b(input val25_t a, input val25_t b);
    logic signed [49:0] w_p;
    w_p = $signed(a) * $signed(b);
    return val25_t'(w_p >>> FRAC_W);
  endfunction

endpackage

// File: rtl/hrm_seq_25b_if.sv
// rtl/hrm_seq_25b_if.sv - start/control and theta stream signals of the rotation sequencer
interface hrm_seq_25b_if #(parameter int CNT_W = 8);
  import hrm_seq_25b_pkg::*;

  logic             i_start;
  angle25_t         i_alpha;
  angle25_t         i_delta;
  logic [CNT_W-1:0] i_count;
  logic             o_busy;
  angle25_t         o_theta;
  logic             o_valid;
  logic             i_ready;
  logic             o_last;
  logic             o_done;

  modport master (
    input  i_start, i_alpha, i_delta, i_count, i_ready,
    output o_busy, o_theta, o_valid, o_last, o_done
  );

  modport slave (
    output i_start, i_alpha, i_delta, i_count, i_ready,
    input  o_busy, o_theta, o_valid, o_last, o_done
  );

endinterface

// File: rtl/hrm_seq_25b_hrm.sv
// rtl/hrm_seq_25b_hrm.sv - combinational angle-sum rotator: theta = alpha + delta on sin/cos pairs
module hrm_seq_25b_hrm
  import hrm_seq_25b_pkg::*;
(
  input  angle25_t i_alpha,
  input  angle25_t i_delta,
  output angle25_t o_theta
);

  // sin(a+d) = sin a cos d + cos a sin d ; cos(a+d) = cos a cos d - sin a sin d
  assign o_theta[0] = mlt_25b(i_alpha[0], i_delta[1]) + mlt_25b(i_alpha[1], i_delta[0]);
  assign o_theta[1] = mlt_25b(i_alpha[1], i_delta[1]) - mlt_25b(i_alpha[0], i_delta[0]);

endmodule

// File: rtl/hrm_seq_25b.sv
// rtl/hrm_seq_25b.sv - emits theta_k = alpha + k*delta, k=1..N, over a valid/ready stream
module hrm_seq_25b
  import hrm_seq_25b_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  hrm_seq_25b_if.master io_bus
);

  state_t           r_state;
  angle25_t         r_alpha;
  angle25_t         r_delta;
  angle25_t         r_theta;
  logic [CNT_W-1:0] r_rem;
  logic             r_valid;
  logic             r_last;
  logic             r_done;
  logic             r_busy;

  angle25_t w_rot_in;
  angle25_t w_rot_out;

  // The rotator seeds from the latched start angle once, then feeds back its own registered output.
  always_comb begin
    w_rot_in = r_theta;
    if (r_state == PRIME) w_rot_in = r_alpha;
  end

  hrm_seq_25b_hrm u_hrm_25b (
    .i_alpha (w_rot_in),
    .i_delta (r_delta),
    .o_theta (w_rot_out)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_alpha[0] <= ZERO_25B;
      r_alpha[1] <= ZERO_25B;
      r_delta[0] <= ZERO_25B;
      r_delta[1] <= ZERO_25B;
      r_theta[0] <= ZERO_25B;
      r_theta[1] <= ZERO_25B;
      r_rem      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (io_bus.i_start) begin
            r_alpha <= io_bus.i_alpha;
            r_delta <= io_bus.i_delta;
            r_rem   <= io_bus.i_count;
            r_busy  <= 1'b1;
            if (io_bus.i_count != '0) begin
              r_state <= PRIME;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        PRIME: begin
          r_theta <= w_rot_out;
          r_valid <= 1'b1;
          r_last  <= (r_rem == CNT_W'(1));
          r_state <= HOLD;
        end
        HOLD: begin
          if (io_bus.i_ready) begin
            if (r_rem == CNT_W'(1)) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_theta <= w_rot_out;
              r_rem   <= r_rem - CNT_W'(1);
              r_last  <= (r_rem == CNT_W'(2));
            end
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign io_bus.o_theta = r_theta;
  assign io_bus.o_valid = r_valid;
  assign io_bus.o_last  = r_last;
  assign io_bus.o_done  = r_done;
  assign io_bus.o_busy  = r_busy;

endmodule

// File: tb/tb_hrm_seq_25b.sv
// tb/tb_hrm_seq_25b.sv - scoreboard bench for hrm_seq_25b with a behavioural angle-sum model
module tb_hrm_seq_25b;
  import hrm_seq_25b_pkg::*;

  localparam int CW = 4;
  localparam logic [24:0] NEG_ONE = 25'h180_0000;

  typedef struct {
    logic [24:0] s;
    logic [24:0] c;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hrm_seq_25b_if #(.CNT_W(CW)) bus ();
  hrm_seq_25b #(.CNT_W(CW)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

  beat_t expq[$];
  int errs = 0, checks = 0, cyc = 0, c0 = 0;
  int done_cnt = 0, done_cyc = -1, busy_cnt = 0, beat_cnt = 0, first_valid_cyc = -1;
  logic stalled = 1'b0;
  logic [24:0] prev_s = '0, prev_c = '0;
  bit pat [6] = '{1, 0, 0, 1, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint to_real_int(input logic [24:0] v);
    return v[24] ? longint'(v) - (longint'(1) << 25) : longint'(v);
  endfunction

  // Fixed-point product rounded down: floor(a*b / 2**23).
  function automatic longint fmul(input logic [24:0] a, input logic [24:0] b);
    longint p, q, scale;
    scale = longint'(1) << 23;
    p = to_real_int(a) * to_real_int(b);
    q = p / scale;
    if (p < 0 && q * scale != p) q = q - 1;
    return q;
  endfunction

  task automatic rot(input logic [24:0] as, ac, ds, dc, output logic [24:0] rs, rc);
    rs = 25'(fmul(as, dc) + fmul(ac, ds));
    rc = 25'(fmul(ac, dc) - fmul(as, ds));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid && stalled) begin
        chk("stall_sin", 64'(bus.o_theta[0]), 64'(prev_s));
        chk("stall_cos", 64'(bus.o_theta[1]), 64'(prev_c));
      end
      if (bus.o_valid && bus.i_ready) begin
        beat_t e;
        beat_cnt++;
        if (expq.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("beat_sin", 64'(bus.o_theta[0]), 64'(e.s));
          chk("beat_cos", 64'(bus.o_theta[1]), 64'(e.c));
          chk("beat_last", 64'(bus.o_last), 64'(e.last));
        end
      end
      if (bus.o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      stalled = bus.o_valid && !bus.i_ready;
      prev_s  = bus.o_theta[0];
      prev_c  = bus.o_theta[1];
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_after_all_beats", 64'(expq.size()), 64'd0);
      end
    end
  end

  task automatic do_start(input logic [24:0] as, ac, ds, dc, input int n, input bit model);
    logic [24:0] s, c;
    s = as;
    c = ac;
    @(posedge clk); #1;
    bus.i_start = 1'b1;
    bus.i_alpha[0] = as; bus.i_alpha[1] = ac;
    bus.i_delta[0] = ds; bus.i_delta[1] = dc;
    bus.i_count = CW'(n);
    if (model) begin
      for (int k = 1; k <= n; k++) begin
        rot(s, c, ds, dc, s, c);
        expq.push_back('{s, c, (k == n)});
      end
    end
    first_valid_cyc = -1; busy_cnt = 0; beat_cnt = 0; stalled = 1'b0;
    @(posedge clk); #1;
    c0 = cyc;
    bus.i_start = 1'b0;
    bus.i_alpha[0] = 25'($urandom); bus.i_alpha[1] = 25'($urandom);
    bus.i_delta[0] = 25'($urandom); bus.i_delta[1] = 25'($urandom);
    bus.i_count = CW'($urandom);
  endtask

  task automatic run_until_done(input int mode, input int budget);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      case (mode)
        0:       bus.i_ready = 1'b1;
        1:       bus.i_ready = ($urandom % 4) != 0;
        default: bus.i_ready = (i == 0) ? 1'b0 : ((i <= 6) ? pat[i-1] : 1'b1);
      endcase
      @(posedge clk); #1;
      i++;
    end
    if (done_cnt == d0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [24:0] s0, c0v;
    int n, d0;
    bus.i_start = 1'b0; bus.i_ready = 1'b0; bus.i_count = '0;
    bus.i_alpha[0] = '0; bus.i_alpha[1] = '0; bus.i_delta[0] = '0; bus.i_delta[1] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_last", 64'(bus.o_last), 64'd0);
    chk("rst_done", 64'(bus.o_done), 64'd0);
    chk("rst_sin", 64'(bus.o_theta[0]), 64'd0);
    chk("rst_cos", 64'(bus.o_theta[1]), 64'd0);
    rst = 1'b0;

    s0 = 25'($urandom); c0v = 25'($urandom);
    for (int k = 1; k <= 4; k++) expq.push_back('{s0, c0v, (k == 4)});
    do_start(s0, c0v, ZERO_25B, ONE_25B, 4, 1'b0);
    run_until_done(0, 50);
    chk("id_first_valid", 64'(first_valid_cyc), 64'(c0 + 1));
    chk("id_done_cycle", 64'(done_cyc), 64'(c0 + 5));
    chk("id_beats", 64'(beat_cnt), 64'd4);
    chk("id_busy_cycles", 64'(busy_cnt), 64'd6);

    expq.push_back('{ONE_25B, ZERO_25B, 1'b0});
    expq.push_back('{ZERO_25B, NEG_ONE, 1'b0});
    expq.push_back('{NEG_ONE, ZERO_25B, 1'b0});
    expq.push_back('{ZERO_25B, ONE_25B, 1'b1});
    do_start(ZERO_25B, ONE_25B, ONE_25B, ZERO_25B, 4, 1'b0);
    run_until_done(0, 50);
    chk("quarter_beats", 64'(beat_cnt), 64'd4);

    do_start(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), 3, 1'b1);
    run_until_done(2, 50);
    chk("bp_beats", 64'(beat_cnt), 64'd3);
    chk("bp_done_cycle", 64'(done_cyc), 64'(c0 + 7));

    do_start(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), 0, 1'b1);
    run_until_done(0, 20);
    chk("zero_done_cycle", 64'(done_cyc), 64'(c0));
    chk("zero_busy_cycles", 64'(busy_cnt), 64'd1);
    chk("zero_beats", 64'(beat_cnt), 64'd0);
    chk("zero_no_valid", 64'(first_valid_cyc), 64'(-1));

    do_start(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), 5, 1'b1);
    bus.i_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_count = CW'(15);
    bus.i_alpha[0] = 25'($urandom); bus.i_delta[1] = 25'($urandom);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    run_until_done(0, 50);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_beats", 64'(beat_cnt), 64'd5);
    chk("busy_start_idle", 64'(bus.o_busy), 64'd0);

    do_start(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), 6, 1'b1);
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.o_valid), 64'd0);
    chk("midrst_busy", 64'(bus.o_busy), 64'd0);
    chk("midrst_last", 64'(bus.o_last), 64'd0);
    chk("midrst_sin", 64'(bus.o_theta[0]), 64'd0);
    chk("midrst_cos", 64'(bus.o_theta[1]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt), 64'(d0));
    chk("midrst_done_low", 64'(bus.o_done), 64'd0);
    expq.delete();
    stalled = 1'b0;
    rst = 1'b0;

    do_start(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), 15, 1'b1);
    run_until_done(0, 60);
    chk("max_beats", 64'(beat_cnt), 64'd15);
    chk("max_done_cycle", 64'(done_cyc), 64'(c0 + 16));

    repeat (20) begin
      n = $urandom_range(0, 15);
      do_start(25'($urandom), 25'($urandom), 25'($urandom), 25'($urandom), n, 1'b1);
      run_until_done(1, 300);
      chk("rand_beats", 64'(beat_cnt), 64'(n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
